// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin
// mux select arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters and the arbiter.
// The slave side is the arbiter, the master side drives the requests.
interface mux8_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy
    );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating-priority encoder: returns the first set request bit found when
// scanning from ptr upward, wrapping 7 -> 0.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [SEL_W-1:0]   o_idx
);

    logic [SEL_W-1:0] w_pos;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = i_ptr + SEL_W'(i);
            if (!o_found && i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of the shared 8:1 mux. Tenure is
// capped at HOLD_MAX cycles only while another requester is waiting.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux8_rr_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_sel;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;

    logic [NUM_REQ-1:0]  w_own_mask;
    logic                w_own_req;
    logic                w_others;
    logic                w_hold_done;
    logic                w_rotate;
    logic [NUM_REQ-1:0]  w_pick_req;
    logic                w_found;
    logic [SEL_W-1:0]    w_idx;
    logic                w_new_grant;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // r_sel doubles as the owner index while in GRANT.
    assign w_own_mask  = onehot8(r_sel);
    assign w_own_req   = |(bus.req & w_own_mask);
    assign w_others    = |(bus.req & ~w_own_mask);
    assign w_hold_done = (r_cnt == HOLD_MAX_C);
    assign w_rotate    = (r_state == ST_GRANT) && w_own_req && w_hold_done && w_others;
    assign w_pick_req  = w_rotate ? (bus.req & ~w_own_mask) : bus.req;

    rr_pick8 u_pick (
        .i_req   (w_pick_req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_new_grant = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_new_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_own_req) begin
                    if (w_found) begin
                        w_new_grant = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_rotate) begin
                    w_new_grant = 1'b1;
                end else if (!w_hold_done) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_new_grant) begin
            w_cnt_nxt = CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_new_grant) begin
                r_sel  <= w_idx;
                r_ptr  <= w_idx + SEL_W'(1);
                r_gnt  <= onehot8(w_idx);
                r_busy <= 1'b1;
            end else if (w_state_nxt == ST_IDLE) begin
                r_gnt  <= '0;
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(r_gnt));
    a_gnt_sel:    assert property (@(posedge clk) (r_gnt != '0) |-> (r_gnt[r_sel] && r_busy));

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer for the shared 8-to-1 single-bit multiplexer. Eight requesters compete for the one mux output. The block grants exactly one requester at a time and drives the mux's 3-bit select from that grant. It bounds each tenure to HOLD_MAX cycles under contention so no requester starves.

## Interface
Parameters:
- HOLD_MAX, default 4: maximum consecutive grant cycles for one requester while another is waiting; legal range 1..255.

Ports:
- clk, input, 1: sole clock; all state updates on its rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- req, input, 8: request vector; bit i is requester i, level-sensitive.
- gnt, output, 8: one-hot grant, or all zeros when idle; registered.
- sel, output, 3: index of the granted requester for the mux; sel[2] drives S1 (MSB), sel[1] drives S2, sel[0] drives S3; registered.
- busy, output, 1: high while in GRANT; registered.

## Operation
- Two states:
  - IDLE: gnt = 0, busy = 0, sel holds the last granted index.
  - GRANT: exactly one gnt bit high, busy = 1, sel = index of that bit.
- Pointer ptr (3 bits) is the search start. After each new grant to index k, ptr = (k+1) mod 8.
- Pick function: first i with req[i] = 1, scanning ptr, ptr+1, …, ptr+7 mod 8 (wrap 7→0).
- Hold counter cnt counts cycles of the current tenure:
  - Loads 1 on each new grant.
  - Increments each further GRANT cycle.
  - Saturates at HOLD_MAX.
- Transitions, evaluated every edge:
  - IDLE, req = 0: stay IDLE.
  - IDLE, req ≠ 0: go to GRANT with winner = pick(req, ptr).
  - GRANT, owner k drops req[k], other bits set: grant pick(req, ptr) directly, no idle cycle.
  - GRANT, owner k drops req[k], req = 0: go to IDLE.
  - GRANT, req[k] held, cnt == HOLD_MAX, another bit set: grant pick(req & ~(1<<k), ptr).
  - GRANT, req[k] held, cnt < HOLD_MAX or no other bit set: keep k; cnt saturates and the tenure continues while k is alone.
- HOLD_MAX = 1: under contention the grant rotates every cycle.
- Reset values:
  - state = IDLE, gnt = 8'h00, sel = 3'b000, busy = 0, ptr = 0, cnt = 0.
  - The first grant after reset searches from index 0.
- Reset mid-tenure:
  - Outputs return to reset values on the next rising edge with rst_n low.
  - Arbitration history is discarded.
- Invariants:
  - gnt is never multi-hot.
  - gnt ≠ 0 implies gnt[sel] = 1 and busy = 1.

## Timing
- Request-to-grant latency is 1 cycle: req sampled at edge n gives gnt/sel/busy valid after edge n.
- A deasserting owner loses its grant 1 cycle after its req falls. The hand-off to the next requester happens on that same edge.
- Worst-case wait for a continuously asserting requester: 7 × HOLD_MAX cycles.
- Requesters must keep req high until granted. The block does not latch requests, so a pulse missed by the pick is dropped.
- All outputs come directly from flops; there is no combinational path from req to any output.
- cnt width: 8 bits, sized for HOLD_MAX ≤ 255.

## Structure
- Shared package mux_arb_pkg holds:
  - NUM_REQ = 8 and SEL_W = 3.
  - State encoding: IDLE = 1'b0, GRANT = 1'b1.
- Sub-module rr_pick8 is combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found and idx[2:0], the rotating-priority encoder.
  - It is instantiated once. For the forced-rotation case its request input is masked with ~(1<<k).
- The top level holds the state flop, ptr, cnt, and the registered gnt/sel/busy. gnt is decoded from the next-state index.

## Test plan
- Reset and single requester:
  - Stimulus: hold rst_n = 0 for 2 cycles, then req = 8'h20.
  - Outputs read 0/0/0 during reset.
  - One cycle after req = 8'h20: gnt = 8'h20, sel = 3'b101, busy = 1.
- Forced rotation with HOLD_MAX = 4:
  - Stimulus: req = 8'h81 held.
  - Cycles 1–4: gnt = 8'h01.
  - Cycles 5–8: gnt = 8'h80, sel = 7.
  - Cycle 9: gnt = 8'h01 again (wrap 7→0).
- Early release:
  - Stimulus: owner 2 granted, req = 8'h14; drop bit 2 at cycle 2.
  - Next edge: gnt = 8'h10, sel = 4, busy stays 1 (no idle gap).
- Lone holder:
  - Stimulus: req = 8'h08 for 20 cycles.
  - gnt stays 8'h08 throughout and cnt saturates at HOLD_MAX.
  - Then req = 0: next edge gives gnt = 0, busy = 0, sel = 3.
- Full contention:
  - Stimulus: req = 8'hFF with HOLD_MAX = 1.
  - sel steps 0,1,2,…,7,0 every cycle.
  - gnt is always one-hot and matches sel.
- Mid-tenure reset:
  - Stimulus: assert rst_n = 0 for 1 cycle during a grant to index 6 with req = 8'hC0, then release.
  - Outputs clear on that edge.
  - After release: gnt = 8'h40, because ptr was reset to 0 and the search starts at index 0.
